// File: rtl/mcla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder controller.
// nib_sel works on a fixed 256-bit container, so operands up to 256 bits are supported.
package mcla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NIB_W     = 4;
  localparam int NIB_IDX_W = 6;
  localparam int MAX_VEC_W = NIB_W << NIB_IDX_W;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [MAX_VEC_W-1:0] vec,
                                               input logic [NIB_IDX_W-1:0] idx);
    return vec[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/MCLA_4_c.sv
// 4-bit carry-lookahead adder slice without carry input; 5-bit result.
module MCLA_4_c (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] s
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = 1'b0;
  assign c[1] = g[0];
  assign c[2] = g[1] | (p[1] & g[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign s = {c[4], p ^ c[3:0]};

endmodule

// File: rtl/mcla4_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer around one shared MCLA_4_c slice.
// A nibble with an incoming carry takes a second pass through the slice (+1).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ADD   | add nibble idx of A and B; divert to INC if carry-in is set
// INC   | add 1 to the saved ADD result for nibble idx
// DONE  | result held on out_sum until out_ready
module mcla4_serial_add_ctrl
  import mcla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [4:0]         tmp_q;

  logic [MAX_VEC_W-1:0] a_ext, b_ext;
  logic [NIB_W-1:0]     add_a, add_b;
  logic [4:0]           add_s;
  logic [NIB_W-1:0]     wr_nib;
  logic                 accept, wr_en, tmp_en, carry_new, last;

  assign a_ext = MAX_VEC_W'(a_q);
  assign b_ext = MAX_VEC_W'(b_q);
  assign last  = (idx_q == IDX_W'(NIB - 1));

  MCLA_4_c u_mcla (
    .a (add_a),
    .b (add_b),
    .s (add_s)
  );

  always_comb begin
    state_d   = state_q;
    add_a     = '0;
    add_b     = '0;
    accept    = 1'b0;
    wr_en     = 1'b0;
    tmp_en    = 1'b0;
    wr_nib    = '0;
    carry_new = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        add_a = nib_sel(a_ext, NIB_IDX_W'(idx_q));
        add_b = nib_sel(b_ext, NIB_IDX_W'(idx_q));
        if (carry_q) begin
          tmp_en  = 1'b1;
          state_d = INC;
        end else begin
          wr_en     = 1'b1;
          wr_nib    = add_s[3:0];
          carry_new = add_s[4];
        end
      end
      INC: begin
        add_a     = tmp_q[3:0];
        add_b     = 4'b0001;
        wr_en     = 1'b1;
        wr_nib    = add_s[3:0];
        // tmp_q[4] and add_s[4] are mutually exclusive, so OR is exact
        carry_new = tmp_q[4] | add_s[4];
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr_en) state_d = last ? DONE : ADD;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      tmp_q   <= '0;
    end else begin
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        sum_q   <= '0;
        idx_q   <= '0;
        carry_q <= 1'b0;
      end
      if (tmp_en) tmp_q <= add_s;
      if (wr_en) begin
        carry_q <= carry_new;
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) sum_q[n*NIB_W +: NIB_W] <= wr_nib;
        end
        if (last) sum_q[WIDTH] <= carry_new;
        else      idx_q        <= idx_q + IDX_W'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ADD) || (state_q == INC);
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_mcla4_serial_add_ctrl.sv
// Self-checking bench: vector table, scoreboard queue, corner sequences, 4-bit exhaustive.
module tb_mcla4_serial_add_ctrl;

  localparam int W = 16;
  localparam int NB = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  in_a, in_b;
  logic [W:0]    out_sum;

  logic          iv4, ir4, ov4, or4, busy4;
  logic [3:0]    a4, b4;
  logic [4:0]    s4;

  mcla4_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy)
  );

  mcla4_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4),
    .out_sum(s4), .busy(busy4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W:0] sum;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Number of nibbles (excluding nibble 0) that see an incoming carry.
  function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    int c = 0;
    int s;
    for (int n = 0; n < NB; n++) begin
      if (c != 0) k++;
      s = int'((a >> (4*n)) & 16'hF) + int'((b >> (4*n)) & 16'hF) + c;
      c = s >> 4;
    end
    return k;
  endfunction

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  task automatic op16(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W:0] exp_sum, input int exp_lat);
    exp_t e;
    int   cyc;
    wait_ready(name);
    e.sum = exp_sum;
    e.lat = exp_lat;
    in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_sum"}, 64'(out_sum), 64'(e.sum));
      check({name, "_lat"}, 64'(cyc), 64'(e.lat));
      check({name, "_ready_in_done"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int cyc = 0;
    iv4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk); #1;
    iv4 = 1'b0;
    while (!ov4 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("w4_sum", 64'(s4), 64'({1'b0, a} + {1'b0, b}));
    check("w4_lat", 64'(cyc), 64'd1);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   hold;

    tbl[0] = '{16'h1234, 16'h4321, 17'h05555, 4};
    tbl[1] = '{16'hFFFF, 16'h0001, 17'h10000, 7};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 7};
    tbl[3] = '{16'h0008, 16'h0008, 17'h00010, 5};
    tbl[4] = '{16'h0F0F, 16'h0101, 17'h01010, 6};
    tbl[5] = '{16'h8000, 16'h8000, 17'h10000, 4};
    tbl[6] = '{16'h0000, 16'h0000, 17'h00000, 4};
    tbl[7] = '{16'h7FFF, 16'h0001, 17'h08000, 7};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    rst = 1'b0;

    foreach (tbl[i]) op16($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].lat);

    // Backpressure in DONE with a competing in_valid
    wait_ready("bp");
    in_a = 16'h1234; in_b = 16'h4321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 100 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("bp_sum", 64'(out_sum), 64'h05555);
    hold = out_sum;
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_sum_hold",   64'(out_sum),   64'(hold));
      check("bp_no_ready",   64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready),  64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_not_taken",  64'(in_ready),  64'd1);
    op16("bp_next", 16'h0008, 16'h0008, 17'h00010, 5);

    // Reset during INC of nibble 1
    wait_ready("rst_inc");
    in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_inc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_inc_ready", 64'(in_ready),  64'd1);
    check("rst_inc_valid", 64'(out_valid), 64'd0);
    check("rst_inc_busy0", 64'(busy),      64'd0);
    check("rst_inc_sum",   64'(out_sum),   64'd0);
    rst = 1'b0;
    op16("after_rst", 16'h0001, 16'h0002, 17'h00003, 4);

    // Reset mid-ADD with partially written result
    wait_ready("rst_add");
    in_a = 16'h1234; in_b = 16'h4321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_add_partial", 64'(out_sum), 64'h00055);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_add_sum",   64'(out_sum),  64'd0);
    check("rst_add_ready", 64'(in_ready), 64'd1);

    // Random sweep, biased towards long carry chains
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ~ra + W'($urandom_range(0, 2));
        1: ra = ra | 16'hFFF0;
        default: ;
      endcase
      op16("rnd", ra, rb, {1'b0, ra} + {1'b0, rb}, NB + ref_k(ra, rb));
    end

    // WIDTH=4 exhaustive
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(4'(a), 4'(b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
